// File: rtl/button_intr_ctrl_if.sv
// Interrupt request/acknowledge handshake between the button controller and the processor.
// The controller drives irq/irq_id through the master modport; the processor answers with ack.
interface button_intr_ctrl_if #(
    parameter int unsigned ID_W = 2
) ();

    logic            irq;
    logic [ID_W-1:0] irq_id;
    logic            ack;

    modport master (
        output irq,
        output irq_id,
        input  ack
    );

    modport slave (
        input  irq,
        input  irq_id,
        output ack
    );

endinterface

// File: rtl/button_intr_ctrl.sv
// Push-button event controller: synchronise, debounce and edge-detect each active-low button,
// latch events as pending, and serve them lowest index first over a req/ack interrupt handshake.
module button_intr_ctrl #(
    parameter int unsigned NBTN      = 4,
    parameter int unsigned DEBOUNCE  = 3,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned EDGE_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NBTN-1:0]       btn_n,
    input  logic [NBTN-1:0]       mask,
    button_intr_ctrl_if.master    intr,
    output logic [NBTN-1:0]       level,
    output logic [NBTN-1:0]       pending,
    output logic [NBTN-1:0]       miss
);

    localparam int unsigned    CNT_W   = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    logic [NBTN-1:0]  sync1_q;
    logic [NBTN-1:0]  sync2_q;
    logic [NBTN-1:0]  sample;

    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];

    logic [NBTN-1:0]  level_q;
    logic [NBTN-1:0]  level_d;
    logic [NBTN-1:0]  toggle;
    logic [NBTN-1:0]  evt;

    logic [NBTN-1:0]  pending_q;
    logic [NBTN-1:0]  pending_d;
    logic [NBTN-1:0]  miss_q;
    logic [NBTN-1:0]  miss_d;
    logic [NBTN-1:0]  clr;

    state_e           state_q;
    state_e           state_d;
    logic             irq_q;
    logic             irq_d;
    logic [ID_W-1:0]  irq_id_q;
    logic [ID_W-1:0]  irq_id_d;
    logic [ID_W-1:0]  low_idx;
    logic             ack_hit;

    // Buttons are active-low; the internal sample reads 1 when pressed.
    assign sample = ~sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: level follows the sample only after DEBOUNCE consecutive differing samples.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            cnt_d[i] = '0;
            if (sample[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        level_d = level_q ^ toggle;
    end

    always_comb begin
        case (EDGE_MODE)
            0:       evt = toggle & ~level_q & mask;
            1:       evt = toggle &  level_q & mask;
            default: evt = toggle & mask;
        endcase
    end

    always_comb begin
        low_idx = '0;
        for (int i = int'(NBTN) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            clr[i] = ack_hit && (irq_id_q == ID_W'(i));
        end
    end

    // A new event on the acknowledged channel wins over its clear and is not a loss.
    always_comb begin
        pending_d = (pending_q & ~clr) | evt;
        miss_d    = (miss_q & ~clr) | (evt & pending_q & ~clr);
    end

    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        ack_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    irq_d    = 1'b1;
                    irq_id_d = low_idx;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (intr.ack) begin
                    ack_hit = 1'b1;
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt_q[i] <= '0;
            end
            level_q   <= '0;
            pending_q <= '0;
            miss_q    <= '0;
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign intr.irq    = irq_q;
    assign intr.irq_id = irq_id_q;
    assign level       = level_q;
    assign pending     = pending_q;
    assign miss        = miss_q;

endmodule
